// File: rtl/dual_issue_inst_queue.sv
// Circular instruction queue between fetch and dual-issue dispatch.
// Fetch pushes up to two {pc, inst} pairs per cycle; dispatch sees a
// two-entry show-ahead window at the head and consumes 0..2 entries.
module dual_issue_inst_queue #(
  parameter int DEPTH  = 16,
  parameter int INST_W = 32,
  parameter int PC_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               enq_valid,
  input  logic [PC_W-1:0]          enq_pc0,
  input  logic [INST_W-1:0]        enq_inst0,
  input  logic [PC_W-1:0]          enq_pc1,
  input  logic [INST_W-1:0]        enq_inst1,
  output logic                     enq_ready,
  input  logic [1:0]               deq_count,
  output logic                     out_valid0,
  output logic [PC_W-1:0]          out_pc0,
  output logic [INST_W-1:0]        out_inst0,
  output logic                     out_valid1,
  output logic [PC_W-1:0]          out_pc1,
  output logic [INST_W-1:0]        out_inst1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INST_W;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  logic [1:0]    n_enq, n_deq, deq_req;
  logic [AW-1:0] wr_p1, rd_p1;

  logic [1:0]         slot_vld;
  logic [1:0][AW-1:0] slot_idx;
  logic [1:0][EW-1:0] slot_dat;

  assign wr_p1 = wr_ptr_q + AW'(1);
  assign rd_p1 = rd_ptr_q + AW'(1);

  // Room for a full pair is judged only from the registered occupancy;
  // a same-cycle dequeue does not free space for this cycle's enqueue.
  assign enq_ready = (count_q <= CW'(DEPTH - 2));

  // Enqueue/dequeue amounts: 2'b10 is treated as no write, deq 3 as 2,
  // and dequeue is clamped to what is actually held.
  always_comb begin
    n_enq = 2'd0;
    case (enq_valid)
      2'b01:   n_enq = 2'd1;
      2'b11:   n_enq = 2'd2;
      default: n_enq = 2'd0;
    endcase
    if (!enq_ready) n_enq = 2'd0;

    deq_req = (deq_count == 2'd3) ? 2'd2 : deq_count;
    n_deq   = deq_req;
    if (CW'(deq_req) > count_q) n_deq = count_q[1:0];
  end

  // Pointer and occupancy state; reset beats flush beats normal traffic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + AW'(n_deq);
      wr_ptr_q <= wr_ptr_q + AW'(n_enq);
      count_q  <= count_q + CW'(n_enq) - CW'(n_deq);
    end
  end

  // Storage writes: slot 0 at wr_ptr, slot 1 at the next (wrapping) index.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (n_enq != 2'd0) mem_q[wr_ptr_q] <= {enq_pc0, enq_inst0};
      if (n_enq == 2'd2) mem_q[wr_p1]    <= {enq_pc1, enq_inst1};
    end
  end

  assign slot_idx[0] = rd_ptr_q;
  assign slot_idx[1] = rd_p1;
  assign slot_vld[0] = (count_q >= CW'(1));
  assign slot_vld[1] = (count_q >= CW'(2));

  // Head window; invalid slots present zero pc/inst.
  for (genvar s = 0; s < 2; s++) begin : g_slot
    assign slot_dat[s] = slot_vld[s] ? mem_q[slot_idx[s]] : '0;
  end

  assign out_valid0 = slot_vld[0];
  assign out_pc0    = slot_dat[0][EW-1:INST_W];
  assign out_inst0  = slot_dat[0][INST_W-1:0];
  assign out_valid1 = slot_vld[1];
  assign out_pc1    = slot_dat[1][EW-1:INST_W];
  assign out_inst1  = slot_dat[1][INST_W-1:0];
  assign count      = count_q;

endmodule

// File: tb/tb_dual_issue_inst_queue.sv
// Scoreboard bench for dual_issue_inst_queue: each stimulus step pushes the
// expected post-edge window; a negedge monitor pops and compares.
module tb_dual_issue_inst_queue;

  localparam int DEPTH = 16, INST_W = 32, PC_W = 16;

  logic clk = 1'b0;
  logic rst, flush;
  logic [1:0] enq_valid, deq_count;
  logic [PC_W-1:0] enq_pc0, enq_pc1, out_pc0, out_pc1;
  logic [INST_W-1:0] enq_inst0, enq_inst1, out_inst0, out_inst1;
  logic enq_ready, out_valid0, out_valid1;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    int unsigned cnt;
    bit rdy, v0, v1;
    logic [PC_W-1:0] pc0, pc1;
    logic [INST_W-1:0] i0, i1;
  } exp_t;

  exp_t sb[$];
  logic [PC_W-1:0] mq[$];
  int total = 0, passed = 0;
  logic [PC_W-1:0] pcn;

  dual_issue_inst_queue #(.DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid),
    .enq_pc0(enq_pc0), .enq_inst0(enq_inst0), .enq_pc1(enq_pc1),
    .enq_inst1(enq_inst1), .enq_ready(enq_ready), .deq_count(deq_count),
    .out_valid0(out_valid0), .out_pc0(out_pc0), .out_inst0(out_inst0),
    .out_valid1(out_valid1), .out_pc1(out_pc1), .out_inst1(out_inst1),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] mk(input logic [PC_W-1:0] pc);
    return {~pc, pc};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // One clock of stimulus; the model advances and the expectation is queued.
  task automatic step(input bit r, input bit fl, input logic [1:0] ev,
                      input logic [PC_W-1:0] p0, input logic [PC_W-1:0] p1,
                      input logic [1:0] dc);
    int nd, ne, dq;
    exp_t e;
    rst = r; flush = fl; enq_valid = ev; deq_count = dc;
    enq_pc0 = p0; enq_inst0 = mk(p0); enq_pc1 = p1; enq_inst1 = mk(p1);
    if (r || fl) mq.delete();
    else begin
      dq = (dc == 2'd3) ? 2 : int'(dc);
      nd = (dq > mq.size()) ? mq.size() : dq;
      ne = 0;
      if (mq.size() <= DEPTH - 2) ne = (ev == 2'b01) ? 1 : (ev == 2'b11) ? 2 : 0;
      repeat (nd) void'(mq.pop_front());
      if (ne >= 1) mq.push_back(p0);
      if (ne == 2) mq.push_back(p1);
    end
    e.cnt = mq.size();
    e.rdy = (mq.size() <= DEPTH - 2);
    e.v0  = (mq.size() >= 1);
    e.v1  = (mq.size() >= 2);
    e.pc0 = e.v0 ? mq[0] : '0;
    e.i0  = e.v0 ? mk(mq[0]) : '0;
    e.pc1 = e.v1 ? mq[1] : '0;
    e.i1  = e.v1 ? mk(mq[1]) : '0;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: compare the DUT window against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("count", count, e.cnt);
      chk("enq_ready", enq_ready, e.rdy);
      chk("out_valid0", out_valid0, e.v0);
      chk("out_valid1", out_valid1, e.v1);
      chk("out_pc0", out_pc0, e.pc0);
      chk("out_inst0", out_inst0, e.i0);
      chk("out_pc1", out_pc1, e.pc1);
      chk("out_inst1", out_inst1, e.i1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; flush = 0; enq_valid = 0; deq_count = 0;
    enq_pc0 = 0; enq_pc1 = 0; enq_inst0 = 0; enq_inst1 = 0;
    #2;
    // 1. reset then idle
    step(1, 0, 2'b00, 0, 0, 0);
    step(1, 0, 2'b00, 0, 0, 0);
    step(0, 0, 2'b00, 0, 0, 0);
    chk("rst_count", count, 0);
    chk("rst_valid0", out_valid0, 0);
    chk("rst_pc0", out_pc0, 0);
    chk("rst_ready", enq_ready, 1);

    // 2. fill with pairs, then one dropped pair
    for (int i = 0; i < 8; i++) step(0, 0, 2'b11, 16'(8*i), 16'(8*i+4), 0);
    chk("full_count", count, 16);
    chk("full_ready", enq_ready, 0);
    step(0, 0, 2'b11, 16'h0040, 16'h0044, 0);
    chk("full_drop_count", count, 16);
    chk("full_head_pc", out_pc0, 16'h0000);

    // 3. drain two per cycle
    for (int i = 0; i < 8; i++) step(0, 0, 2'b00, 0, 0, 2);
    chk("drain_count", count, 0);

    // 4. fill to 15 starting mid-array, then hold ~15 across the wrap
    pcn = 16'h0200;
    step(0, 0, 2'b11, 16'h0300, 16'h0304, 0);   // shift pointers off zero
    step(0, 0, 2'b00, 0, 0, 2);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 2'b11, pcn, pcn + 16'd4, 0);
      pcn += 16'd8;
    end
    step(0, 0, 2'b01, pcn, 0, 0);
    pcn += 16'd4;
    chk("fill15_count", count, 15);
    for (int i = 0; i < 14; i++) begin
      automatic bit acc = (mq.size() <= DEPTH - 2);
      step(0, 0, 2'b11, pcn, pcn + 16'd4, 1);
      if (acc) pcn += 16'd8;
    end
    for (int i = 0; i < 7; i++) step(0, 0, 2'b00, 0, 0, 2);

    // 5. clamped dequeue from count 1
    chk("pre_clamp_count", count, 1);
    step(0, 0, 2'b00, 0, 0, 2);
    chk("clamp_count", count, 0);
    chk("clamp_valid0", out_valid0, 0);
    chk("clamp_valid1", out_valid1, 0);

    // illegal 2'b10 writes nothing; deq 3 behaves as 2
    step(0, 0, 2'b10, 16'h0500, 16'h0504, 0);
    chk("ev10_count", count, 0);
    step(0, 0, 2'b11, 16'h0600, 16'h0604, 0);
    step(0, 0, 2'b11, 16'h0608, 16'h060C, 0);
    step(0, 0, 2'b00, 0, 0, 3);
    chk("deq3_pc0", out_pc0, 16'h0608);

    // 6. flush with count 6 and concurrent traffic
    step(0, 0, 2'b11, 16'h0700, 16'h0704, 0);
    step(0, 0, 2'b11, 16'h0708, 16'h070C, 0);
    chk("preflush_count", count, 6);
    step(0, 1, 2'b11, 16'h0710, 16'h0714, 2);
    chk("flush_count", count, 0);
    chk("flush_valid0", out_valid0, 0);
    step(0, 0, 2'b01, 16'h0100, 0, 0);
    chk("postflush_pc0", out_pc0, 16'h0100);

    // reset mid-stream then fresh enqueue
    step(0, 0, 2'b11, 16'h0800, 16'h0804, 0);
    step(1, 0, 2'b11, 16'h0900, 16'h0904, 1);
    step(0, 0, 2'b11, 16'h0A00, 16'h0A04, 0);
    chk("postrst_pc1", out_pc1, 16'h0A04);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
